// File: rtl/spi_reg_slave_pkg.sv
// Frame constants and FSM state encoding shared by the SPI register slave.
// Pure declarations: no latency or flow control of its own.
package spi_reg_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int RW_BIT     = 15;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle (CS, SCLK, MOSI, MISO) between an SPI master and the register slave.
// Wires only: no latency; SPI has no backpressure.
interface spi_reg_slave_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_sync_edge.sv
// 2-flop synchronizer plus registered rise/fall detect for one asynchronous pin.
// Latency: level after 2 cycles, edge pulse 3 cycles after the pin moves; no backpressure.
module spi_sync_edge (
  input  logic master_clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1;
  logic dly;

  // Reset to 0 so a pin already low at reset release never looks like a falling edge.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      q    <= 1'b0;
      dly  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      q    <= s1;
      dly  <= q;
      rise <= q & ~dly;
      fall <= ~q & dly;
    end
  end
endmodule

// File: rtl/spi_reg_slave.sv
// Oversampled SPI mode-0 slave turning 16-bit frames into register writes; commit 4 cycles after 16th SCLK pin edge.
// No backpressure; `SPI_REG_READBACK_EN adds register readback on MISO (otherwise MISO is tied 0).
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                  master_clk,
  input  logic                  reset,
  spi_reg_slave_if.slave        spi,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  frame_err
);
  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge u_cs   (.master_clk(master_clk), .reset(reset), .d(spi.spi_cs_n),
                        .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge u_sclk (.master_clk(master_clk), .reset(reset), .d(spi.spi_sclk),
                        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_mosi (.master_clk(master_clk), .reset(reset), .d(spi.spi_mosi),
                        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_ok;
  assign unused_ok = &{1'b0, cs_q, sclk_q, mosi_rise, mosi_fall, sclk_fall};

  state_t                state, state_n;
  logic [4:0]            cnt, cnt_n;
  logic [FRAME_BITS-1:0] sh, sh_n, sh_shift;
  logic [NUM_REGS*8-1:0] regs_n;
  logic [ADDR_W-1:0]     wr_addr_n;
  logic                  wr_stb_n, frame_err_n, wr_ok;

  assign sh_shift = {sh[FRAME_BITS-2:0], mosi_q};
  assign wr_ok    = !sh_shift[RW_BIT] && (int'(sh_shift[RW_BIT-1 -: ADDR_W]) < NUM_REGS);

`ifdef SPI_REG_READBACK_EN
  logic [DATA_W-1:0] tx, tx_n, rd_byte;
  logic              miso, miso_n;

  // After 8 bits the low byte of the shifter holds {R/W, addr}; out-of-range reads give 0.
  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sh_shift[DATA_W-1] && sh_shift[ADDR_W-1:0] == ADDR_W'(i))
        rd_byte = regs_out[i*8 +: 8];
  end

  assign spi.spi_miso = miso;
`else
  assign spi.spi_miso = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    regs_n      = regs_out;
    wr_addr_n   = wr_addr;
    wr_stb_n    = 1'b0;
    frame_err_n = 1'b0;
`ifdef SPI_REG_READBACK_EN
    tx_n        = tx;
    miso_n      = miso;
`endif
    case (state)
      IDLE: begin
`ifdef SPI_REG_READBACK_EN
        miso_n = 1'b0;
        tx_n   = '0;
`endif
        if (cs_fall) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sh_n    = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
`ifdef SPI_REG_READBACK_EN
          miso_n      = 1'b0;
`endif
        end else if (sclk_rise) begin
          sh_n  = sh_shift;
          cnt_n = cnt + 5'd1;
`ifdef SPI_REG_READBACK_EN
          if (cnt == 5'(DATA_W - 1))
            tx_n = rd_byte;
`endif
          if (cnt == 5'(FRAME_BITS - 1)) begin
            state_n = DONE;
`ifdef SPI_REG_READBACK_EN
            miso_n  = 1'b0;
`endif
            if (wr_ok) begin
              wr_stb_n  = 1'b1;
              wr_addr_n = sh_shift[RW_BIT-1 -: ADDR_W];
              for (int i = 0; i < NUM_REGS; i++)
                if (sh_shift[RW_BIT-1 -: ADDR_W] == ADDR_W'(i))
                  regs_n[i*8 +: 8] = sh_shift[DATA_W-1:0];
            end
          end
        end
`ifdef SPI_REG_READBACK_EN
        else if (sclk_fall) begin
          miso_n = tx[DATA_W-1];
          tx_n   = {tx[DATA_W-2:0], 1'b0};
        end
`endif
      end
      DONE: begin
`ifdef SPI_REG_READBACK_EN
        miso_n = 1'b0;
`endif
        if (cs_rise)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      regs_out  <= '0;
      wr_addr   <= '0;
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_REG_READBACK_EN
      tx        <= '0;
      miso      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      regs_out  <= regs_n;
      wr_addr   <= wr_addr_n;
      wr_stb    <= wr_stb_n;
      frame_err <= frame_err_n;
`ifdef SPI_REG_READBACK_EN
      tx        <= tx_n;
      miso      <= miso_n;
`endif
    end
  end
endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed-frame bench for spi_reg_slave: a byte-array model of the register file plus pulse/latency monitors.
`timescale 1ns/1ps
module tb_spi_reg_slave;
  localparam int NR = 8;

  logic          master_clk = 1'b0;
  logic          reset;
  logic [NR*8-1:0] regs_out;
  logic          wr_stb;
  logic [6:0]    wr_addr;
  logic          frame_err;

  spi_reg_slave_if spi ();

  spi_reg_slave #(.NUM_REGS(NR), .ADDR_W(7)) dut (
    .master_clk(master_clk),
    .reset     (reset),
    .spi       (spi),
    .regs_out  (regs_out),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 master_clk = ~master_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise16_cyc = 0;
  int csrise_cyc = 0;
  int seen_stb = 0;
  int seen_err = 0;
  bit busy = 1'b1;

  logic [7:0] m_regs [NR];
  logic [6:0] m_addr;

  always @(posedge master_clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  // Compare process: pulse latency on every pulse, register file and idle MISO whenever no frame is in flight.
  always @(negedge master_clk) begin
    if (!reset) begin
      if (wr_stb) begin
        seen_stb++;
        chk("stb_latency", 64'(cyc - rise16_cyc), 64'd4);
      end
      if (frame_err) begin
        seen_err++;
        chk("err_latency", 64'(cyc - csrise_cyc), 64'd4);
      end
`ifndef SPI_REG_READBACK_EN
      chk("miso_tied0", 64'(spi.spi_miso), 64'd0);
`endif
      if (!busy) begin
        chk("regs_out", 64'(regs_out), 64'(model_flat()));
        chk("wr_addr", 64'(wr_addr), 64'(m_addr));
        chk("miso_idle", 64'(spi.spi_miso), 64'd0);
      end
    end
  end

  task automatic spi_frame(input logic [15:0] fr, input int nbits, input int rst_at,
                           output logic [15:0] mbits);
    int s0, e0, exp_s, exp_e, idx;
    busy  = 1'b1;
    s0    = seen_stb;
    e0    = seen_err;
    exp_s = 0;
    exp_e = 0;
    mbits = '0;
    @(negedge master_clk);
    spi.spi_cs_n = 1'b0;
    repeat (8) @(negedge master_clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (3) @(negedge master_clk);
        reset = 1'b0;
        repeat (8) @(negedge master_clk);
      end
      spi.spi_mosi = (i < 16) ? fr[15-i] : 1'b0;
      repeat (8) @(negedge master_clk);
      if (i < 16) mbits[15-i] = spi.spi_miso;
      spi.spi_sclk = 1'b1;
      if (i == 15) rise16_cyc = cyc;
      repeat (8) @(negedge master_clk);
      spi.spi_sclk = 1'b0;
    end
    repeat (8) @(negedge master_clk);
    spi.spi_cs_n = 1'b1;
    csrise_cyc   = cyc;
    repeat (16) @(negedge master_clk);
    // Model: a reset wipes everything, short frames error, full in-range writes commit once.
    idx = int'(fr[14:8]);
    if (rst_at >= 0 && rst_at < nbits) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      m_addr = '0;
    end else if (nbits < 16) begin
      exp_e = 1;
    end else if (!fr[15] && idx < NR) begin
      m_regs[idx] = fr[7:0];
      m_addr      = fr[14:8];
      exp_s       = 1;
    end
    chk("stb_count", 64'(seen_stb - s0), 64'(exp_s));
    chk("err_count", 64'(seen_err - e0), 64'(exp_e));
    busy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mb;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_addr       = '0;
    reset        = 1'b1;
    spi.spi_cs_n = 1'b1;
    spi.spi_sclk = 1'b0;
    spi.spi_mosi = 1'b0;
    repeat (4) @(negedge master_clk);
    chk("rst_regs", 64'(regs_out), 64'd0);
    chk("rst_stb", 64'(wr_stb), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_miso", 64'(spi.spi_miso), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge master_clk);
    busy = 1'b0;

    spi_frame(16'h03A5, 16, -1, mb);
    chk("w3_reg3", 64'(regs_out[31:24]), 64'hA5);
    chk("w3_addr", 64'(wr_addr), 64'd3);
    chk("w3_others", 64'({regs_out[63:32], regs_out[23:0]}), 64'd0);

    spi_frame(16'h1077, 16, -1, mb);
    chk("oob_reg3", 64'(regs_out[31:24]), 64'hA5);
    chk("oob_addr", 64'(wr_addr), 64'd3);

    spi_frame(16'h0611, 9, -1, mb);
    chk("short_reg6", 64'(regs_out[55:48]), 64'h00);
    spi_frame(16'h0611, 16, -1, mb);
    chk("after_short_reg6", 64'(regs_out[55:48]), 64'h11);

    spi_frame(16'h015A, 20, -1, mb);
    chk("long_reg1", 64'(regs_out[15:8]), 64'h5A);
    chk("long_addr", 64'(wr_addr), 64'd1);

    spi_frame(16'h0000, 0, -1, mb);

    spi_frame(16'h8700, 16, -1, mb);
    chk("read_no_commit_addr", 64'(wr_addr), 64'd1);
`ifndef SPI_REG_READBACK_EN
    chk("read_miso_zero", 64'(mb), 64'd0);
`endif

    spi_frame(16'h07EE, 16, 6, mb);
    chk("rstmid_regs", 64'(regs_out), 64'd0);
    chk("rstmid_addr", 64'(wr_addr), 64'd0);
    spi_frame(16'h07EE, 16, -1, mb);
    chk("post_rst_reg7", 64'(regs_out[63:56]), 64'hEE);

`ifdef SPI_REG_READBACK_EN
    spi_frame(16'h02C3, 16, -1, mb);
    spi_frame(16'h8200, 16, -1, mb);
    chk("rb_data", 64'(mb[7:0]), 64'hC3);
    chk("rb_cmd_phase", 64'(mb[15:8]), 64'h00);
    spi_frame(16'h9000, 16, -1, mb);
    chk("rb_oob", 64'(mb), 64'd0);
`endif

    repeat (10) @(negedge master_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
